// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction cache: refill FSM states, block geometry
// and the word-select helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } icache_state_t;

    localparam int unsigned BLOCK_BYTES      = 16;
    localparam int unsigned BLOCK_BITS       = BLOCK_BYTES * 8;
    localparam int unsigned WORD_OFFSET_BITS = 2;

    // Word 0 occupies the least significant 32 bits of a block.
    function automatic logic [31:0] select_word(
        input logic [BLOCK_BITS-1:0]       blk,
        input logic [WORD_OFFSET_BITS-1:0] off
    );
        return blk[32*off +: 32];
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the direct-mapped instruction cache: combinational
// read port, synchronous write port, valid bits cleared asynchronously by reset.
module icache_line_store
    import cpu_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 3,
    parameter int unsigned TAG_BITS   = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    output logic                  o_rd_valid,
    output logic [TAG_BITS-1:0]   o_rd_tag,
    output logic [BLOCK_BITS-1:0] o_rd_data,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_BITS-1:0]   i_wr_tag,
    input  logic [BLOCK_BITS-1:0] i_wr_data
);

    localparam int unsigned LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [BLOCK_BITS-1:0] r_data [LINES];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are never observed while the line is invalid.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache with zero-cycle hits and a
// MEM_READ/UPDATE refill FSM. Optional hit/miss counters under ICACHE_STATS_EN.
module instr_cache
    import cpu_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 3,
    parameter int unsigned ADDR_BITS  = 10
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_BITS-1:0]  address,
    output logic [31:0]           instruction,
    output logic                  busywait,
    output logic                  mem_read,
    output logic [ADDR_BITS-5:0]  mem_address,
    input  logic [BLOCK_BITS-1:0] mem_readdata,
    input  logic                  mem_busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);

    localparam int unsigned BLK_ADDR_BITS = ADDR_BITS - 4;
    localparam int unsigned TAG_BITS      = BLK_ADDR_BITS - INDEX_BITS;

    icache_state_t r_state;
    icache_state_t w_next_state;

    logic [BLK_ADDR_BITS-1:0]    r_blk_addr;
    logic [INDEX_BITS-1:0]       w_index;
    logic [TAG_BITS-1:0]         w_tag;
    logic [WORD_OFFSET_BITS-1:0] w_offset;
    logic                        w_rd_valid;
    logic [TAG_BITS-1:0]         w_rd_tag;
    logic [BLOCK_BITS-1:0]       w_rd_data;
    logic                        w_hit;
    logic                        w_fill;
    logic                        w_unused;

    assign w_offset = address[2 +: WORD_OFFSET_BITS];
    assign w_index  = address[4 +: INDEX_BITS];
    assign w_tag    = address[ADDR_BITS-1 -: TAG_BITS];
    assign w_unused = ^address[1:0];

    icache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_line_store (
        .i_clk      (CLK),
        .i_rst      (RESET),
        .i_rd_index (w_index),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_fill),
        .i_wr_index (r_blk_addr[INDEX_BITS-1:0]),
        .i_wr_tag   (r_blk_addr[BLK_ADDR_BITS-1 -: TAG_BITS]),
        .i_wr_data  (mem_readdata)
    );

    assign w_hit = w_rd_valid && (w_rd_tag == w_tag);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_blk_addr <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && !w_hit) begin
                r_blk_addr <= address[ADDR_BITS-1:4];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        busywait     = 1'b0;
        mem_read     = 1'b0;
        w_fill       = 1'b0;
        instruction  = '0;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    instruction = select_word(w_rd_data, w_offset);
                end else begin
                    busywait     = 1'b1;
                    w_next_state = MEM_READ;
                end
            end
            MEM_READ: begin
                mem_read = 1'b1;
                busywait = 1'b1;
                if (!mem_busywait) begin
                    w_next_state = UPDATE;
                end
            end
            UPDATE: begin
                busywait     = 1'b1;
                w_fill       = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
        // Reset silences every output even though the cleared cache reads as a miss.
        if (RESET) begin
            busywait    = 1'b0;
            mem_read    = 1'b0;
            w_fill      = 1'b0;
            instruction = '0;
        end
    end

    assign mem_address = r_blk_addr;

`ifdef ICACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == IDLE) begin
            if (w_hit && r_hit_count != 16'hFFFF) begin
                r_hit_count <= r_hit_count + 16'd1;
            end
            if (!w_hit && r_miss_count != 16'hFFFF) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Randomized self-checking bench for instr_cache against a valid/tag reference
// model and a fixed-latency instruction-memory model.
module tb_instr_cache;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [9:0]   address = '0;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata = '0;
    logic         mem_busywait = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    instr_cache #(
        .INDEX_BITS (3),
        .ADDR_BITS  (10)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [5:0] blk, input int unsigned w);
        logic [7:0] wb;
        wb = 8'(w);
        return {8'hA5, 2'b00, blk, wb, 8'h3C ^ {2'b00, blk}};
    endfunction

    function automatic logic [127:0] mem_block(input logic [5:0] blk);
        return {mem_word(blk, 3), mem_word(blk, 2), mem_word(blk, 1), mem_word(blk, 0)};
    endfunction

    // Memory: data valid mem_lat cycles after the request is first seen.
    int unsigned mem_lat = 5;
    int unsigned mem_cnt = 0;

    always @(negedge CLK) begin
        if (mem_read) begin
            mem_cnt++;
            if (mem_cnt < mem_lat) begin
                mem_busywait = 1'b1;
            end else begin
                mem_busywait = 1'b0;
                mem_readdata = mem_block(mem_address);
            end
        end else begin
            mem_cnt      = 0;
            mem_busywait = 1'b0;
        end
    end

    // Reference model: which block each line holds, plus event counters.
    logic        m_valid [8];
    logic [2:0]  m_tag   [8];
    int unsigned m_hits   = 0;
    int unsigned m_misses = 0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic bump(inout int unsigned cnt);
        if (cnt < 16'hFFFF) cnt++;
    endtask

    task automatic fetch(input logic [9:0] a);
        logic        exp_hit;
        int unsigned cycles;
        int unsigned idx;
        int unsigned off;
        idx = int'(a[6:4]);
        off = int'(a[3:2]);
        address = a;
        #1;
        exp_hit = m_valid[idx] && (m_tag[idx] == a[9:7]);
        check("busywait_comb", {31'd0, busywait}, {31'd0, !exp_hit});
        if (exp_hit) begin
            check("hit_instr", instruction, mem_word(a[9:4], off));
            @(posedge CLK);
            #1;
            bump(m_hits);
        end else begin
            bump(m_misses);
            @(posedge CLK);
            #1;
            check("req_mem_read", {31'd0, mem_read}, 32'd1);
            check("req_mem_address", {26'd0, mem_address}, {26'd0, a[9:4]});
            cycles = 1;
            while (busywait && cycles < 200) begin
                @(posedge CLK);
                #1;
                cycles++;
            end
            check("miss_penalty", cycles, mem_lat + 2);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = a[9:7];
            check("fill_instr", instruction, mem_word(a[9:4], off));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busywait"}, {31'd0, busywait}, 32'd0);
        check({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
        check({tag, "_mem_address"}, {26'd0, mem_address}, 32'd0);
        check({tag, "_instruction"}, instruction, 32'd0);
    endtask

    task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
        check({tag, "_hit_count"}, {16'd0, hit_count}, m_hits);
        check({tag, "_miss_count"}, {16'd0, miss_count}, m_misses);
`else
        if (tag.len() == 0) $display("empty stats tag");
`endif
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        model_reset();
        #1 RESET = 1'b1;
        #2;
        check_reset_outputs("reset");
        check_stats("reset");
        #3 RESET = 1'b0;

        // Cold miss, then sequential hits within the refilled block.
        mem_lat = 5;
        fetch(10'h000);
        fetch(10'h004);
        fetch(10'h008);
        fetch(10'h00C);
        // Same index, different tag: evicts block 0.
        fetch(10'h080);
        check_stats("seq");
        fetch(10'h000);

        // Reset two cycles into a refill aborts it.
        address = 10'h080;
        #1;
        check("abort_miss", {31'd0, busywait}, 32'd1);
        @(posedge CLK);
        repeat (2) @(posedge CLK);
        #1;
        check("abort_in_mem_read", {31'd0, mem_read}, 32'd1);
        RESET = 1'b1;
        #1;
        check_reset_outputs("abort");
        model_reset();
        check_stats("abort");
        #1 RESET = 1'b0;
        mem_lat = 2;
        fetch(10'h000);

        // Address moves mid-refill: latched block still fills, new address misses after.
        mem_lat = 3;
        address = 10'h010;
        #1;
        check("chg_miss", {31'd0, busywait}, 32'd1);
        bump(m_misses);
        @(posedge CLK);
        #1;
        check("chg_mem_address", {26'd0, mem_address}, 32'd1);
        address = 10'h020;
        #1;
        check("chg_stall", {31'd0, busywait}, 32'd1);
        repeat (mem_lat + 1) @(posedge CLK);
        #1;
        check("chg_idle_no_read", {31'd0, mem_read}, 32'd0);
        m_valid[1] = 1'b1;
        m_tag[1]   = 3'd0;
        address = 10'h010;
        #1;
        check("chg_line1_hit", {31'd0, busywait}, 32'd0);
        check("chg_line1_data", instruction, mem_word(6'd1, 0));
        fetch(10'h020);

        for (int i = 0; i < 60; i++) begin
            logic [9:0] a;
            mem_lat = $urandom_range(1, 5);
            a = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom), 2'b00};
            fetch(a);
        end
        check_stats("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
